// File: rtl/gr8_dram_pkg.sv
// rtl/gr8_dram_pkg.sv - shared types and constants for the GR8 DRAM scheduler
package gr8_dram_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REF,
    ST_DMA,
    ST_PRE,
    ST_CPU,
    ST_CPU_END,
    ST_HREF
  } sched_state_t;

  localparam logic [2:0] PH_DEC  = 3'd0;
  localparam logic [2:0] PH_PRE  = 3'd3;
  localparam logic [2:0] PH_CPU  = 3'd4;
  localparam logic [2:0] PH_IDLE = 3'd7;

  localparam int BANK_BIT = 22;

  // Returns {cas1, cas0} for the selected bank.
  function automatic logic [1:0] cas_sel(input logic bank);
    return bank ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/gr8_ref_timer.sv
// rtl/gr8_ref_timer.sv - refresh period counter, saturating pending count and overflow flag
module gr8_ref_timer #(
  parameter int REF_PERIOD  = 13,
  parameter int REF_BACKLOG = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       svc,
  output logic [2:0] ref_pend,
  output logic       ref_ovf
);

  localparam int CNT_W = $clog2(REF_PERIOD + 1);

  logic [CNT_W-1:0] cnt;
  logic             inc;

  assign inc = tick && (cnt == CNT_W'(REF_PERIOD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= '0;
      ref_pend <= 3'd0;
      ref_ovf  <= 1'b0;
    end else begin
      if (tick) begin
        cnt <= inc ? '0 : cnt + CNT_W'(1);
      end
      // A request and a service in the same clock cancel out.
      if (inc && !svc) begin
        if (ref_pend == 3'(REF_BACKLOG)) begin
          ref_ovf <= 1'b1;
        end else begin
          ref_pend <= ref_pend + 3'd1;
        end
      end else if (svc && !inc && ref_pend != 3'd0) begin
        ref_pend <= ref_pend - 3'd1;
      end
    end
  end

endmodule

// File: rtl/gr8_dram_sched.sv
// rtl/gr8_dram_sched.sv - DRAM scheduler: refresh / DMA pre-slot, CPU slot, registered strobes
// Optional HIDDEN_REF_EN: CBR refresh in an unused CPU slot.
module gr8_dram_sched
  import gr8_dram_pkg::*;
#(
  parameter int REF_PERIOD  = 13,
  parameter int REF_BACKLOG = 4,
  parameter int ADDR_W      = 24
) (
  input  logic              C7M,
  input  logic              RES,
  input  logic              s_cyc,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  output logic              dma_ack,
  output logic              ras,
  output logic              cas0,
  output logic              cas1,
  output logic              asel,
  output logic              rwe,
  output logic [2:0]        ref_pend,
  output logic              ref_ovf
);

  sched_state_t state;
  logic [2:0]   ph;
  logic         dma_bank;
  logic         dma_we_q;
  logic         cpu_bank;
  logic         cpu_we_q;
  logic         ref_svc;

  // Addresses reach the DRAM through the external row/column mux; only the bank bit steers CAS here.
  logic unused_addr;
  assign unused_addr = ^{cpu_addr, dma_addr};

  assign ref_svc = (ph == 3'd2 && state == ST_REF) || (ph == 3'd5 && state == ST_HREF);

  gr8_ref_timer #(
    .REF_PERIOD (REF_PERIOD),
    .REF_BACKLOG(REF_BACKLOG)
  ) u_ref_timer (
    .clk     (C7M),
    .rst     (RES),
    .tick    (s_cyc),
    .svc     (ref_svc),
    .ref_pend(ref_pend),
    .ref_ovf (ref_ovf)
  );

  // Strobes are computed for the phase being entered, so each is valid for the whole phase.
  always_ff @(posedge C7M or posedge RES) begin
    if (RES) begin
      state    <= ST_IDLE;
      ph       <= PH_IDLE;
      ras      <= 1'b0;
      cas0     <= 1'b0;
      cas1     <= 1'b0;
      asel     <= 1'b0;
      rwe      <= 1'b0;
      dma_ack  <= 1'b0;
      dma_bank <= 1'b0;
      dma_we_q <= 1'b0;
      cpu_bank <= 1'b0;
      cpu_we_q <= 1'b0;
    end else begin
      ras     <= 1'b0;
      cas0    <= 1'b0;
      cas1    <= 1'b0;
      asel    <= 1'b0;
      rwe     <= 1'b0;
      dma_ack <= 1'b0;
      if (s_cyc) begin
        ph    <= PH_DEC;
        state <= ST_IDLE;
      end else begin
        if (ph != PH_IDLE) begin
          ph <= ph + 3'd1;
        end
        case (ph)
          PH_DEC: begin
            dma_bank <= dma_addr[BANK_BIT];
            dma_we_q <= dma_we;
            if (ref_pend == 3'(REF_BACKLOG) || (ref_pend != 3'd0 && !dma_req)) begin
              state <= ST_REF;
              cas0  <= 1'b1;
              cas1  <= 1'b1;
            end else if (dma_req) begin
              state <= ST_DMA;
              ras   <= 1'b1;
              rwe   <= dma_we;
            end else begin
              state <= ST_IDLE;
            end
          end
          3'd1: begin
            if (state == ST_REF) begin
              ras  <= 1'b1;
              cas0 <= 1'b1;
              cas1 <= 1'b1;
            end else if (state == ST_DMA) begin
              ras          <= 1'b1;
              asel         <= 1'b1;
              {cas1, cas0} <= cas_sel(dma_bank);
              rwe          <= dma_we_q;
              dma_ack      <= 1'b1;
            end
          end
          3'd2: begin
            state <= ST_PRE;
          end
          PH_PRE: begin
            if (cpu_req) begin
              state    <= ST_CPU;
              ras      <= 1'b1;
              rwe      <= cpu_we;
              cpu_bank <= cpu_addr[BANK_BIT];
              cpu_we_q <= cpu_we;
            end
`ifdef HIDDEN_REF_EN
            else if (ref_pend != 3'd0) begin
              state <= ST_HREF;
              cas0  <= 1'b1;
              cas1  <= 1'b1;
            end
`endif
            else begin
              state <= ST_IDLE;
            end
          end
          PH_CPU, 3'd5: begin
            if (state == ST_CPU) begin
              ras          <= 1'b1;
              asel         <= 1'b1;
              {cas1, cas0} <= cas_sel(cpu_bank);
              rwe          <= cpu_we_q;
            end
`ifdef HIDDEN_REF_EN
            else if (state == ST_HREF && ph == PH_CPU) begin
              ras  <= 1'b1;
              cas0 <= 1'b1;
              cas1 <= 1'b1;
            end
`endif
          end
          3'd6: begin
            state <= (state == ST_CPU) ? ST_CPU_END : ST_IDLE;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
